instr_fetch: RTL and testbench

Instruction fetch stage, sitting directly upstream of the instruction decoder. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. Each returned 32-bit instruction word is presented with its PC in a registered output slot (`o_ir`/`o_pc`/`o_valid`) that feeds the decoder's `i_ir`. It supports downstream stall through a one-entry skid buffer, and branch redirect with flush, including squash of an in-flight memory read.

---
 rtl/instr_fetch.sv | 153 +++++++++++++++
 tb/tb_instr_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack,
// and drives a registered decoder slot backed by a one-entry skid buffer.
module instr_fetch #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  output logic                o_imem_req,
  input  logic                i_imem_ack,
  input  logic [31:0]         i_imem_data,
  input  logic                i_stall,
  input  logic                i_redirect,
  input  logic [PC_WIDTH-1:0] i_redirect_pc,
  output logic [31:0]         o_ir,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FULL,
    S_DISCARD
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [31:0]         ir_q, ir_d;
  logic [PC_WIDTH-1:0] opc_q, opc_d;
  logic                valid_q, valid_d;
  logic [31:0]         skid_ir_q, skid_ir_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;

  logic                consume;
  logic                writable;
  logic [PC_WIDTH-1:0] pc_inc;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    ir_d      = ir_q;
    opc_d     = opc_q;
    valid_d   = valid_q;
    skid_ir_d = skid_ir_q;
    skid_pc_d = skid_pc_q;

    consume  = valid_q && !i_stall;
    writable = !valid_q || consume;
    pc_inc   = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    if (i_redirect) begin
      valid_d   = 1'b0;
      ir_d      = '0;
      skid_ir_d = '0;
      skid_pc_d = '0;
      unique case (state_q)
        S_FETCH: begin
          if (i_imem_ack) begin
            pc_d    = i_redirect_pc;
            state_d = S_FETCH;
          end else begin
            // The read stays outstanding at pc_q; the target waits until it returns.
            tgt_d   = i_redirect_pc;
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          tgt_d = i_redirect_pc;
          if (i_imem_ack) begin
            pc_d    = i_redirect_pc;
            state_d = S_FETCH;
          end
        end
        default: begin
          pc_d    = i_redirect_pc;
          state_d = S_FETCH;
        end
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (i_imem_ack) begin
            pc_d = pc_inc;
            if (writable) begin
              ir_d    = i_imem_data;
              opc_d   = pc_q;
              valid_d = 1'b1;
            end else begin
              skid_ir_d = i_imem_data;
              skid_pc_d = pc_q;
              state_d   = S_FULL;
            end
          end else if (consume) begin
            valid_d = 1'b0;
            ir_d    = '0;
          end
        end
        S_FULL: begin
          if (!i_stall) begin
            ir_d      = skid_ir_q;
            opc_d     = skid_pc_q;
            valid_d   = 1'b1;
            skid_ir_d = '0;
            skid_pc_d = '0;
            state_d   = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (i_imem_ack) begin
            pc_d    = tgt_q;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      tgt_q     <= RESET_PC;
      ir_q      <= '0;
      opc_q     <= '0;
      valid_q   <= 1'b0;
      skid_ir_q <= '0;
      skid_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      ir_q      <= ir_d;
      opc_q     <= opc_d;
      valid_q   <= valid_d;
      skid_ir_q <= skid_ir_d;
      skid_pc_q <= skid_pc_d;
    end
  end

  // pc_q is frozen during DISCARD, so the squashed address stays on the bus until ack.
  assign o_imem_req  = (state_q == S_FETCH) || (state_q == S_DISCARD);
  assign o_imem_addr = pc_q;
  assign o_ir        = ir_q;
  assign o_pc        = opc_q;
  assign o_valid     = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a program-order scoreboard of expected PCs
// plus protocol monitors, with directed phases for latency, stall, redirect, wrap and reset.
module tb_instr_fetch;

  localparam int          PW  = 16;
  localparam logic [15:0] RPC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] o_imem_addr;
  logic        o_imem_req;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_data = '0;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [15:0] i_redirect_pc = '0;
  logic [31:0] o_ir;
  logic [15:0] o_pc;
  logic        o_valid;

  instr_fetch #(.PC_WIDTH(PW), .RESET_PC(RPC)) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .o_imem_addr(o_imem_addr),
    .o_imem_req(o_imem_req),
    .i_imem_ack(i_imem_ack),
    .i_imem_data(i_imem_data),
    .i_stall(i_stall),
    .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_ir(o_ir),
    .o_pc(o_pc),
    .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Program-order reference: the PCs the decoder must see, in order.
  logic [15:0] exp_q[$];
  logic [15:0] exp_next;
  int          wcnt = 0;
  int          cur_lat = 0;
  int          lat_min = 0;
  int          lat_max = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'h0300_0000 + {16'h0000, a};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 16'd1;
    end
  endtask

  task automatic flush_to(input logic [15:0] pc);
    exp_q.delete();
    exp_next = pc;
    refill();
  endtask

  task automatic redirect(input logic [15:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    flush_to(pc);
    $display("redirect to %h", pc);
  endtask

  // One cycle: memory model reacts to the request, then stall/redirect are applied.
  task automatic step(input logic st, input logic rd, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    if (!o_imem_req) begin
      i_imem_ack  = 1'b0;
      i_imem_data = $urandom;
      wcnt        = 0;
    end else if (wcnt >= cur_lat) begin
      i_imem_ack  = 1'b1;
      i_imem_data = mem_word(o_imem_addr);
      wcnt        = 0;
      cur_lat     = $urandom_range(lat_max, lat_min);
    end else begin
      i_imem_ack  = 1'b0;
      i_imem_data = $urandom;
      wcnt++;
    end
    i_stall    = st;
    i_redirect = 1'b0;
    if (rd) redirect(rpc);
    refill();
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [15:0] prev_addr = '0;
  logic        pend = 1'b0;
  logic [15:0] pend_pc = '0;

  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
        pend     = 1'b0;
      end else begin
        if (!o_valid) chk(o_ir == 32'h0, "nop_when_invalid", o_ir, 32'h0);
        if (o_valid && !i_stall && !i_redirect) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "scoreboard_empty", {16'h0, o_pc}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            $display("consume pc=%h ir=%h exp_pc=%h", o_pc, o_ir, e);
            chk(o_pc == e, "out_pc", {16'h0, o_pc}, {16'h0, e});
            chk(o_ir == mem_word(e), "out_ir", o_ir, mem_word(e));
          end
        end
        if (prev_req && !prev_ack)
          chk(o_imem_req && (o_imem_addr == prev_addr), "req_hold",
              {15'h0, o_imem_req, o_imem_addr}, {15'h0, 1'b1, prev_addr});
        if (pend) begin
          if (!o_imem_req) begin
            chk(1'b0, "redirect_req_gap", 32'h0, 32'h1);
            pend = 1'b0;
          end else if (!prev_req || prev_ack) begin
            chk(o_imem_addr == pend_pc, "redirect_target", {16'h0, o_imem_addr}, {16'h0, pend_pc});
            pend = 1'b0;
          end
        end
        if (i_redirect) begin
          pend    = 1'b1;
          pend_pc = i_redirect_pc;
        end
        prev_req  = o_imem_req;
        prev_ack  = i_imem_ack;
        prev_addr = o_imem_addr;
      end
    end
  end

  initial begin
    int          n;
    logic [15:0] saved;
    bit          found;

    flush_to(RPC);
    repeat (3) @(posedge clk);
    #1;
    chk(o_valid == 1'b0, "reset_valid", {31'h0, o_valid}, 32'h0);
    chk(o_ir == 32'h0, "reset_ir", o_ir, 32'h0);
    chk(o_pc == 16'h0, "reset_pc", {16'h0, o_pc}, 32'h0);
    chk(o_imem_req == 1'b0, "reset_req", {31'h0, o_imem_req}, 32'h0);
    chk(o_imem_addr == RPC, "reset_addr", {16'h0, o_imem_addr}, {16'h0, RPC});

    // First valid: IDLE->FETCH, ack in the first request cycle, valid one cycle later.
    rst_n = 1'b1;
    n = 0;
    while (!o_valid && n < 10) begin
      step(1'b0, 1'b0, 16'h0);
      n++;
    end
    chk(n == 2, "first_valid_latency", n, 2);

    // Back-to-back throughput with single-cycle memory.
    n = 0;
    repeat (20) begin
      step(1'b0, 1'b0, 16'h0);
      if (o_valid) n++;
    end
    chk(n == 20, "stream_no_bubble", n, 20);

    // Stall for 3 cycles: skid fills, request drops, slot holds.
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    chk(!o_imem_req && o_valid, "stall_full_1", {30'h0, o_imem_req, o_valid}, 32'h1);
    step(1'b1, 1'b0, 16'h0);
    chk(!o_imem_req && o_valid, "stall_full_2", {30'h0, o_imem_req, o_valid}, 32'h1);
    repeat (6) step(1'b0, 1'b0, 16'h0);

    // Redirect coincident with an ack.
    chk(i_imem_ack == 1'b1, "redir_ack_setup", {31'h0, i_imem_ack}, 32'h1);
    redirect(16'h0100);
    step(1'b0, 1'b0, 16'h0);
    chk(!o_valid && o_ir == 32'h0, "redir_ack_flush", {o_ir[30:0], o_valid}, 32'h0);
    chk(o_imem_req && o_imem_addr == 16'h0100, "redir_ack_req",
        {15'h0, o_imem_req, o_imem_addr}, {15'h0, 1'b1, 16'h0100});
    repeat (6) step(1'b0, 1'b0, 16'h0);

    // Redirect during the first wait cycle of a 3-cycle read.
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 1'b0, 16'h0);
      if (o_imem_req && !i_imem_ack && wcnt == 1) found = 1'b1;
    end
    chk(found, "inflight_setup", {31'h0, found}, 32'h1);
    saved = o_imem_addr;
    redirect(16'h0100);
    step(1'b0, 1'b0, 16'h0);
    chk(o_imem_req && o_imem_addr == saved && !o_valid, "discard_hold",
        {14'h0, o_valid, o_imem_req, o_imem_addr}, {14'h0, 1'b0, 1'b1, saved});
    repeat (20) step(1'b0, 1'b0, 16'h0);

    // Wrap-around of the word address.
    lat_min = 0;
    lat_max = 0;
    cur_lat = 0;
    step(1'b0, 1'b1, 16'hFFFE);
    repeat (10) step(1'b0, 1'b0, 16'h0);

    // Random traffic: variable latency, stalls, redirects (some near the wrap point).
    lat_max = 3;
    repeat (3000) begin
      logic        st;
      logic        rd;
      logic [15:0] rpc;
      st  = ($urandom_range(3, 0) == 0);
      rd  = ($urandom_range(19, 0) == 0);
      rpc = ($urandom_range(7, 0) == 0) ? 16'hFFFE : 16'($urandom);
      step(st, rd, rpc);
    end

    // Asynchronous reset while the skid buffer is full.
    lat_max = 0;
    cur_lat = 0;
    repeat (4) step(1'b0, 1'b0, 16'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b0, 16'h0);
      if (!o_imem_req && o_valid) found = 1'b1;
    end
    chk(found, "reach_full", {31'h0, found}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk(o_valid == 1'b0, "areset_valid", {31'h0, o_valid}, 32'h0);
    chk(o_ir == 32'h0, "areset_ir", o_ir, 32'h0);
    chk(o_pc == 16'h0, "areset_pc", {16'h0, o_pc}, 32'h0);
    chk(o_imem_req == 1'b0, "areset_req", {31'h0, o_imem_req}, 32'h0);
    chk(o_imem_addr == RPC, "areset_addr", {16'h0, o_imem_addr}, {16'h0, RPC});
    i_stall    = 1'b0;
    i_redirect = 1'b0;
    i_imem_ack = 1'b0;
    wcnt       = 0;
    flush_to(RPC);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) step(1'b0, 1'b0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
